// File: rtl/mem_arbiter_if.sv
// Bus bundle between the request unit / datapath, the arbiter and the RAM.
// slave  : the arbiter's view (takes requests and RAM responses, drives hits and RAM controls)
// master : the environment's view (drives requests and RAM responses)
interface mem_arbiter_if;
  // request unit / datapath side
  logic        iREN;
  logic        dREN;
  logic        dWEN;
  logic [31:0] iaddr;
  logic [31:0] daddr;
  logic [31:0] dstore;
  logic        ihit;
  logic        dhit;
  logic [31:0] iload;
  logic [31:0] dload;
  // RAM side
  logic        ramREN;
  logic        ramWEN;
  logic [31:0] ramaddr;
  logic [31:0] ramstore;
  logic [31:0] ramload;
  logic        ram_ready;
  // status
  logic        mem_err;

  modport slave (
    input  iREN, dREN, dWEN, iaddr, daddr, dstore, ramload, ram_ready,
    output ihit, dhit, iload, dload, ramREN, ramWEN, ramaddr, ramstore, mem_err
  );

  modport master (
    output iREN, dREN, dWEN, iaddr, daddr, dstore, ramload, ram_ready,
    input  ihit, dhit, iload, dload, ramREN, ramWEN, ramaddr, ramstore, mem_err
  );
endinterface

// File: rtl/mem_arbiter.sv
// mem_arbiter: arbitrates instruction fetch and data accesses onto one
// single-ported RAM, one access in flight at a time. Data wins over fetch.
// Optional feature: define MEMARB_TIMEOUT_EN to abort accesses that wait
// TIMEOUT_CYCLES for ram_ready and raise the sticky mem_err flag.
module mem_arbiter #(
  parameter int TIMEOUT_CYCLES = 255,
  parameter int CNT_W          = 8
) (
  input logic          CLK,
  input logic          nRST,
  mem_arbiter_if.slave bus
);

  typedef enum logic [1:0] {IDLE, DACC, IACC} state_t;

  state_t      r_state;
  state_t      w_next;
  logic [31:0] r_addr;
  logic [31:0] r_store;
  logic        r_wr;
  logic        r_mem_err;
  logic        w_timeout;
  logic        w_d_req;

  logic        w_ihit;
  logic        w_dhit;
  logic [31:0] w_iload;
  logic [31:0] w_dload;
  logic        w_ramREN;
  logic        w_ramWEN;
  logic [31:0] w_ramaddr;
  logic [31:0] w_ramstore;

  assign w_d_req = bus.dREN | bus.dWEN;

`ifdef MEMARB_TIMEOUT_EN
  logic [CNT_W-1:0] r_wait_cnt;

  // A stalled access gives up once it has waited TIMEOUT_CYCLES for the RAM.
  assign w_timeout = (r_state != IDLE) && !bus.ram_ready &&
                     (r_wait_cnt == CNT_W'(TIMEOUT_CYCLES));

  // Wait counter: cleared on grant, counts every unanswered access cycle.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      r_wait_cnt <= '0;
    end else if (r_state == IDLE) begin
      r_wait_cnt <= '0;
    end else if (!bus.ram_ready && !w_timeout) begin
      r_wait_cnt <= r_wait_cnt + CNT_W'(1);
    end
  end

  // Sticky error flag, only cleared by reset.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST)          r_mem_err <= 1'b0;
    else if (w_timeout) r_mem_err <= 1'b1;
  end
`else
  logic w_unused_cfg;
  assign w_unused_cfg = ^{TIMEOUT_CYCLES, CNT_W};
  assign w_timeout    = 1'b0;
  assign r_mem_err    = 1'b0;
`endif

  // State register.
  always_ff @(posedge CLK or negedge nRST) begin
    // NOTE: sequential state uses non-blocking (<=) so every flop samples pre-edge values.
    if (!nRST) r_state <= IDLE;
    else       r_state <= w_next;
  end

  // Grant-edge latches: the RAM is driven only from these while an access is in flight.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      r_addr  <= '0;
      r_store <= '0;
      r_wr    <= 1'b0;
    end else if (r_state == IDLE) begin
      if (w_d_req) begin
        r_addr  <= bus.daddr;
        r_store <= bus.dstore;
        r_wr    <= bus.dWEN;
      end else if (bus.iREN) begin
        r_addr  <= bus.iaddr;
        r_store <= '0;
        r_wr    <= 1'b0;
      end
    end
  end

  // Next-state and outputs: completion beats abort; data beats fetch in IDLE.
  always_comb begin
    // NOTE: every output gets a default first so no path leaves one unassigned (no latches).
    w_next     = r_state;
    w_ihit     = 1'b0;
    w_dhit     = 1'b0;
    w_iload    = '0;
    w_dload    = '0;
    w_ramREN   = 1'b0;
    w_ramWEN   = 1'b0;
    w_ramaddr  = '0;
    w_ramstore = '0;
    case (r_state)
      IDLE: begin
        if (w_d_req)       w_next = DACC;
        else if (bus.iREN) w_next = IACC;
      end
      DACC: begin
        w_ramREN   = !r_wr;
        w_ramWEN   = r_wr;
        w_ramaddr  = r_addr;
        w_ramstore = r_wr ? r_store : 32'h0;
        if (bus.ram_ready) begin
          w_dhit  = 1'b1;
          w_dload = bus.ramload;
          w_next  = IDLE;
        end else if (!w_d_req || w_timeout) begin
          w_next = IDLE;
        end
      end
      IACC: begin
        w_ramREN  = 1'b1;
        w_ramaddr = r_addr;
        if (bus.ram_ready) begin
          w_ihit  = 1'b1;
          w_iload = bus.ramload;
          w_next  = IDLE;
        end else if (!bus.iREN || w_timeout) begin
          w_next = IDLE;
        end
      end
      default: w_next = IDLE;
    endcase
  end

  assign bus.ihit     = w_ihit;
  assign bus.dhit     = w_dhit;
  assign bus.iload    = w_iload;
  assign bus.dload    = w_dload;
  assign bus.ramREN   = w_ramREN;
  assign bus.ramWEN   = w_ramWEN;
  assign bus.ramaddr  = w_ramaddr;
  assign bus.ramstore = w_ramstore;
  assign bus.mem_err  = r_mem_err;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter. Inputs change 1 ns after a rising edge,
// outputs are sampled 1 ns later, well away from the active edge.
module tb_mem_arbiter;

  logic CLK;
  logic nRST;
  int   n_tests;
  int   n_fail;

  mem_arbiter_if bus ();

  mem_arbiter #(.TIMEOUT_CYCLES(4), .CNT_W(8)) dut (
    .CLK  (CLK),
    .nRST (nRST),
    .bus  (bus.slave)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // advance one clock, then let new inputs settle away from the edge
  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  initial begin
    n_tests       = 0;
    n_fail        = 0;
    nRST          = 1'b0;
    bus.iREN      = 1'b0;
    bus.dREN      = 1'b0;
    bus.dWEN      = 1'b0;
    bus.iaddr     = '0;
    bus.daddr     = '0;
    bus.dstore    = '0;
    bus.ramload   = '0;
    bus.ram_ready = 1'b0;

    // reset state
    #12;
    check("rst_ramREN", 32'(bus.ramREN), 32'd0);
    check("rst_ramWEN", 32'(bus.ramWEN), 32'd0);
    check("rst_ramaddr", bus.ramaddr, 32'd0);
    check("rst_hits", 32'({bus.ihit, bus.dhit}), 32'd0);
    check("rst_mem_err", 32'(bus.mem_err), 32'd0);
    nRST = 1'b1;

    // T1: instruction fetch, hit one cycle after request
    tick();
    bus.iREN  = 1'b1;
    bus.iaddr = 32'h40;
    settle();
    check("t1_idle_ramREN", 32'(bus.ramREN), 32'd0);
    tick();
    check("t1_ramREN", 32'(bus.ramREN), 32'd1);
    check("t1_ramWEN", 32'(bus.ramWEN), 32'd0);
    check("t1_ramaddr", bus.ramaddr, 32'h40);
    check("t1_no_hit_yet", 32'(bus.ihit), 32'd0);
    bus.ram_ready = 1'b1;
    bus.ramload   = 32'h8C010004;
    settle();
    check("t1_ihit", 32'(bus.ihit), 32'd1);
    check("t1_iload", bus.iload, 32'h8C010004);
    check("t1_dhit", 32'(bus.dhit), 32'd0);
    tick();
    bus.iREN      = 1'b0;
    bus.ram_ready = 1'b0;
    settle();
    check("t1_ihit_gone", 32'(bus.ihit), 32'd0);
    check("t1_iload_zero", bus.iload, 32'd0);
    check("t1_back_idle", 32'(bus.ramREN), 32'd0);

    // T2: data write beats fetch; fetch follows after one IDLE cycle
    bus.iREN   = 1'b1;
    bus.iaddr  = 32'h44;
    bus.dWEN   = 1'b1;
    bus.dREN   = 1'b1;
    bus.daddr  = 32'h100;
    bus.dstore = 32'hDEADBEEF;
    tick();
    check("t2_ramWEN", 32'(bus.ramWEN), 32'd1);
    check("t2_ramREN", 32'(bus.ramREN), 32'd0);
    check("t2_ramaddr", bus.ramaddr, 32'h100);
    check("t2_ramstore", bus.ramstore, 32'hDEADBEEF);
    bus.ram_ready = 1'b1;
    bus.ramload   = 32'h0BAD0BAD;
    settle();
    check("t2_dhit", 32'(bus.dhit), 32'd1);
    check("t2_ihit_held", 32'(bus.ihit), 32'd0);
    tick();
    bus.dWEN      = 1'b0;
    bus.dREN      = 1'b0;
    bus.ram_ready = 1'b0;
    settle();
    check("t2_idle_gap", 32'({bus.ramREN, bus.ramWEN, bus.dhit}), 32'd0);
    tick();
    check("t2_iacc_ramREN", 32'(bus.ramREN), 32'd1);
    check("t2_iacc_ramaddr", bus.ramaddr, 32'h44);
    check("t2_iacc_ramstore", bus.ramstore, 32'd0);
    bus.ram_ready = 1'b1;
    bus.ramload   = 32'h00000011;
    settle();
    check("t2_ihit", 32'(bus.ihit), 32'd1);
    check("t2_iload", bus.iload, 32'h11);
    tick();
    bus.iREN      = 1'b0;
    bus.ram_ready = 1'b0;

    // T3: data read with three wait cycles
    bus.dREN  = 1'b1;
    bus.daddr = 32'h80;
    tick();
    for (int i = 0; i < 3; i++) begin
      check($sformatf("t3_wait%0d_ramREN", i), 32'(bus.ramREN), 32'd1);
      check($sformatf("t3_wait%0d_dhit", i), 32'(bus.dhit), 32'd0);
      tick();
    end
    bus.ram_ready = 1'b1;
    bus.ramload   = 32'h1234;
    settle();
    check("t3_dhit", 32'(bus.dhit), 32'd1);
    check("t3_dload", bus.dload, 32'h1234);
    tick();
    bus.dREN      = 1'b0;
    bus.ram_ready = 1'b0;

    // T4: mid-access address change ignored, then abort without hit
    bus.dREN  = 1'b1;
    bus.daddr = 32'h80;
    tick();
    check("t4_ramaddr", bus.ramaddr, 32'h80);
    bus.daddr = 32'h84;
    settle();
    check("t4_addr_latched", bus.ramaddr, 32'h80);
    tick();
    check("t4_addr_still", bus.ramaddr, 32'h80);
    bus.dREN = 1'b0;
    settle();
    check("t4_no_dhit", 32'(bus.dhit), 32'd0);
    tick();
    check("t4_aborted", 32'({bus.ramREN, bus.dhit}), 32'd0);

    // drop and ready in the same cycle: hit still delivered
    bus.dREN  = 1'b1;
    bus.daddr = 32'h90;
    tick();
    bus.dREN      = 1'b0;
    bus.ram_ready = 1'b1;
    bus.ramload   = 32'h55;
    settle();
    check("drop_ready_dhit", 32'(bus.dhit), 32'd1);
    check("drop_ready_dload", bus.dload, 32'h55);
    tick();
    // ram_ready in IDLE with no request is ignored
    check("idle_ready_hits", 32'({bus.ihit, bus.dhit}), 32'd0);
    tick();
    check("idle_ready_stay", 32'(bus.ramREN), 32'd0);
    bus.ram_ready = 1'b0;

    // T5: async reset during IACC
    bus.iREN  = 1'b1;
    bus.iaddr = 32'h200;
    tick();
    check("t5_iacc", 32'(bus.ramREN), 32'd1);
    bus.ram_ready = 1'b1;
    nRST          = 1'b0;
    settle();
    check("t5_rst_ramREN", 32'(bus.ramREN), 32'd0);
    check("t5_rst_ihit", 32'(bus.ihit), 32'd0);
    bus.iREN      = 1'b0;
    bus.ram_ready = 1'b0;
    #2;
    nRST = 1'b1;
    tick();
    check("t5_idle_after", 32'({bus.ramREN, bus.ihit}), 32'd0);

`ifdef MEMARB_TIMEOUT_EN
    // T6: timeout abort after TIMEOUT_CYCLES=4 wait cycles, sticky error
    bus.dREN  = 1'b1;
    bus.daddr = 32'h300;
    tick();
    for (int i = 0; i < 5; i++) begin
      check($sformatf("t6_wait%0d_ramREN", i), 32'(bus.ramREN), 32'd1);
      check($sformatf("t6_wait%0d_dhit", i), 32'(bus.dhit), 32'd0);
      tick();
    end
    bus.dREN = 1'b0;
    settle();
    check("t6_aborted", 32'(bus.ramREN), 32'd0);
    check("t6_mem_err", 32'(bus.mem_err), 32'd1);
    tick();
    tick();
    check("t6_mem_err_sticky", 32'(bus.mem_err), 32'd1);
`else
    check("mem_err_tied", 32'(bus.mem_err), 32'd0);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
